// File: rtl/booth_multiplier.sv
// booth_multiplier: iterative radix-2 Booth signed 32x32->64 multiplier, one iteration per clock.
// Define MULT_UNSIGNED_EN to add the uns port (zero-extended operands for MULTU).
module booth_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef MULT_UNSIGNED_EN
   input  logic             uns,
`endif
   output logic [WIDTH-1:0] high,
   output logic [WIDTH-1:0] low,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 2);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH:0]   m_q, m_d, acc_q, acc_d, q_q, q_d, sum;
   logic             q1_q, q1_d, sext;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] high_q, high_d, low_q, low_d;
   logic [2*WIDTH+2:0] sh;
`ifdef MULT_UNSIGNED_EN
   assign sext = ~uns;
`else
   assign sext = 1'b1;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         high_q  <= '0;
         low_q   <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         high_q  <= high_d;
         low_q   <= low_d;
      end
   end
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      high_d  = high_q;
      low_d   = low_q;
      sum     = (q_q[0] & ~q1_q) ? acc_q - m_q : (~q_q[0] & q1_q) ? acc_q + m_q : acc_q;
      // {acc, Q, q_1} shifted right arithmetically by one after the add/sub
      sh      = {sum[WIDTH], sum, q_q};
      if (state_q == IDLE && start) begin
         state_d = RUN;
         m_d     = {sext & A[WIDTH-1], A};
         q_d     = {sext & B[WIDTH-1], B};
         acc_d   = '0;
         q1_d    = 1'b0;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         acc_d = sh[2*WIDTH+2:WIDTH+2];
         q_d   = sh[WIDTH+1:1];
         q1_d  = sh[0];
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH)) begin
            state_d          = DONE;
            {high_d, low_d}  = sh[2*WIDTH:1];
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   assign high = high_q;
   assign low  = low_q;
   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed-vector bench checking latency, results, busy/done and reset abort.
module tb_booth_multiplier;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] A, B, high, low;
   logic        busy, done;
`ifdef MULT_UNSIGNED_EN
   logic        uns = 1'b0;
`endif
   int checks = 0;
   int errors = 0;
   int dones;
   logic [31:0] prev_hi = '0, prev_lo = '0;

   booth_multiplier #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
`ifdef MULT_UNSIGNED_EN
      .uns(uns),
`endif
      .high(high), .low(low), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; A = 32'hDEADBEEF; B = 32'h0BADF00D;
      check({tag, " busy@E0"}, busy, 1);
      check({tag, " done@E0"}, done, 0);
      repeat (32) @(posedge clk);
      #1;
      check({tag, " done@E32"}, done, 0);
      check({tag, " hold@E32"}, {high, low}, {prev_hi, prev_lo});
      @(posedge clk); #1;
      check({tag, " done@E33"}, done, 1);
      check({tag, " busy@E33"}, busy, 1);
      check({tag, " product"}, {high, low}, {eh, el});
      @(posedge clk); #1;
      check({tag, " done@E34"}, done, 0);
      check({tag, " busy@E34"}, busy, 0);
      prev_hi = eh; prev_lo = el;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out", {busy, done, high, low}, 66'd0);
      @(negedge clk); rst = 1'b0;
      run("7*-3", 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run("min*min", 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      run("x*0", 32'h12345678, 32'h0, 32'h0, 32'h0);
      run("-1*-1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
      run("max*min", 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
      run("x*-1", 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988);
`ifdef MULT_UNSIGNED_EN
      uns = 1'b1;
      run("u max*max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      uns = 1'b0;
`endif
      // start while busy must be ignored
      @(negedge clk);
      A = 32'd6; B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; dones = 0;
      for (int e = 1; e <= 34; e++) begin
         if (e == 10) begin A = 32'h55555555; B = 32'h55555555; start = 1'b1; end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) dones++;
      end
      check("busy start done count", dones, 1);
      check("busy start product", {high, low}, 64'd42);
      check("busy start idle", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("no queued op", {busy, done}, 2'b00);
      prev_hi = 32'd0; prev_lo = 32'd42;
      // asynchronous reset mid-operation
      @(negedge clk);
      A = 32'h00010000; B = 32'h00010000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort async", {busy, done, high, low}, 66'd0);
      repeat (2) @(posedge clk);
      #1;
      check("abort held", {busy, done, high, low}, 66'd0);
      @(negedge clk); rst = 1'b0;
      prev_hi = '0; prev_lo = '0;
      run("3*5", 32'd3, 32'd5, 32'd0, 32'd15);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
